// File: rtl/dm_byteen_responder.sv
// Data-memory responder for the CPU M stage: combinational word reads, byte-enabled
// stores, a registered store-trace record and sticky/saturating out-of-range error tracking.
module dm_byteen_responder #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned IDX_W       = 12,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      m_data_addr,
  input  logic [31:0]      m_data_wdata,
  input  logic [3:0]       m_data_byteen,
  input  logic [31:0]      m_inst_addr,
  output logic [31:0]      m_data_rdata,
  output logic             trace_valid,
  output logic [31:0]      trace_pc,
  output logic [31:0]      trace_addr,
  output logic [31:0]      trace_data,
  output logic             err_oob,
  output logic [CNT_W-1:0] err_count
);

  // One bit wider than the address so the byte limit itself is representable.
  localparam logic [32:0] LimitBytes = 33'(DEPTH_WORDS) << 2;

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic             r_trace_valid;
  logic [31:0]      r_trace_pc;
  logic [31:0]      r_trace_addr;
  logic [31:0]      r_trace_data;
  logic             r_err_oob;
  logic [CNT_W-1:0] r_err_count;

  logic             w_in_range;
  logic             w_store;
  logic             w_store_ok;
  logic             w_store_oob;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_cur_word;
  logic [31:0]      w_merged;

  assign w_in_range  = {1'b0, m_data_addr} < LimitBytes;
  assign w_idx       = m_data_addr[IDX_W+1:2];
  assign w_store     = |m_data_byteen;
  assign w_store_ok  = w_store && w_in_range;
  assign w_store_oob = w_store && !w_in_range;

  always_comb begin
    w_cur_word = 32'h0;
    if (w_in_range) begin
      w_cur_word = r_mem[w_idx];
    end
  end

  // Pre-store word, so a read in the store cycle sees the old contents.
  assign m_data_rdata = w_cur_word;

  always_comb begin
    w_merged = w_cur_word;
    for (int i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) begin
        w_merged[8*i +: 8] = m_data_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_store_ok) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_trace_valid <= 1'b0;
      r_trace_pc    <= 32'h0;
      r_trace_addr  <= 32'h0;
      r_trace_data  <= 32'h0;
    end else begin
      r_trace_valid <= w_store_ok;
      if (w_store_ok) begin
        r_trace_pc   <= m_inst_addr;
        r_trace_addr <= {m_data_addr[31:2], 2'b00};
        r_trace_data <= w_merged;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_oob   <= 1'b0;
      r_err_count <= '0;
    end else if (w_store_oob) begin
      r_err_oob <= 1'b1;
      if (r_err_count != {CNT_W{1'b1}}) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign trace_valid = r_trace_valid;
  assign trace_pc    = r_trace_pc;
  assign trace_addr  = r_trace_addr;
  assign trace_data  = r_trace_data;
  assign err_oob     = r_err_oob;
  assign err_count   = r_err_count;

endmodule
